// File: rtl/seque_gen_pkg.sv
// Shared types and constants for the seque_gen serial pattern generator.
package seque_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap,
        StDone
    } state_t;

    localparam int unsigned REPEAT_W   = 8;
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned MIN_REPEAT = 1;

endpackage

// File: rtl/seque_gen_if.sv
// Request/serial-output bundle of seque_gen; master drives requests, slave is the generator.
interface seque_gen_if #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
);
    import seque_pkg::*;

    logic                start;
    logic [MAX_LEN-1:0]  pattern_in;
    logic [LEN_W-1:0]    length_in;
    logic [REPEAT_W-1:0] repeat_in;
    logic [GAP_W-1:0]    gap_in;
    logic                sequence_out;
    logic                bit_valid;
    logic                busy;
    logic                done;

    modport master (
        output start, pattern_in, length_in, repeat_in, gap_in,
        input  sequence_out, bit_valid, busy, done
    );

    modport slave (
        input  start, pattern_in, length_in, repeat_in, gap_in,
        output sequence_out, bit_valid, busy, done
    );

endinterface

// File: rtl/seque_gen_piso.sv
// Loadable MSB-first parallel-in serial-out register with a variable active length.
module seque_piso #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] data_in,
    input  logic [LEN_W-1:0]   len_in,
    output logic               serial_out
);
    localparam int unsigned      IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    logic [MAX_LEN-1:0] data_q;
    logic [LEN_W-1:0]   len_q;
    logic               serial_q;
    logic [IdxW-1:0]    load_msb;
    logic [IdxW-1:0]    held_msb;

    // Length is never 0 when load/shift fire, so len-1 always fits the index.
    assign load_msb = IdxW'(len_in - LenOne);
    assign held_msb = IdxW'(len_q - LenOne);

    // serial_q is the registered output bit; it reads 0 whenever nothing is shifted out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            len_q    <= '0;
            serial_q <= 1'b0;
        end else if (load) begin
            data_q   <= data_in << 1;
            len_q    <= len_in;
            serial_q <= data_in[load_msb];
        end else if (shift) begin
            data_q   <= data_q << 1;
            serial_q <= data_q[held_msb];
        end else begin
            serial_q <= 1'b0;
        end
    end

    assign serial_out = serial_q;

endmodule

// File: rtl/seque_gen.sv
// Serial pattern generator: sends a latched pattern MSB-first, repeated with optional idle gaps.
module seque_gen
    import seque_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input logic        clock,
    input logic        reset,
    seque_gen_if.slave bus
);
    localparam logic [LEN_W-1:0]    LenMax = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]    LenOne = LEN_W'(1);
    localparam logic [REPEAT_W-1:0] RepOne = REPEAT_W'(1);
    localparam logic [REPEAT_W-1:0] RepMin = REPEAT_W'(MIN_REPEAT);
    localparam logic [GAP_W-1:0]    GapOne = GAP_W'(1);

    state_t              state_q, state_d;
    logic [MAX_LEN-1:0]  pattern_q;
    logic [LEN_W-1:0]    len_q;
    logic [GAP_W-1:0]    gap_q;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;

    logic                accept;
    logic [LEN_W-1:0]    eff_len;
    logic [REPEAT_W-1:0] eff_rep;
    logic [REPEAT_W-1:0] rep_left;
    logic                load;
    logic                shift;
    logic [MAX_LEN-1:0]  load_data;
    logic [LEN_W-1:0]    load_len;

    assign accept   = (state_q == StIdle) && bus.start;
    assign eff_len  = (bus.length_in > LenMax) ? LenMax : bus.length_in;
    assign eff_rep  = (bus.repeat_in == '0) ? RepMin : bus.repeat_in;
    assign rep_left = rep_q - RepOne;

    // The first load comes straight from the inputs; later repetitions reload the latched copy.
    assign load_data = (state_q == StIdle) ? bus.pattern_in : pattern_q;
    assign load_len  = (state_q == StIdle) ? eff_len : len_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            gap_q     <= '0;
        end else if (accept) begin
            pattern_q <= bus.pattern_in;
            len_q     <= eff_len;
            gap_q     <= bus.gap_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (eff_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                        idx_d   = eff_len - LenOne;
                        rep_d   = eff_rep;
                        load    = 1'b1;
                    end
                end
            end
            StShift: begin
                if (idx_q == '0) begin
                    rep_d = rep_left;
                    if (rep_left == '0) begin
                        state_d = StDone;
                    end else if (gap_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_q;
                    end else begin
                        idx_d = len_q - LenOne;
                        load  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - LenOne;
                    shift = 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapOne) begin
                    state_d   = StShift;
                    gap_cnt_d = '0;
                    idx_d     = len_q - LenOne;
                    load      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the cycle they describe.
    always_comb begin
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        valid_d = (state_d == StShift);
    end

    seque_piso #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_piso (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .shift      (shift),
        .data_in    (load_data),
        .len_in     (load_len),
        .serial_out (bus.sequence_out)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bit_valid = valid_q;

endmodule

// File: tb/tb_seque_gen.sv
// Self-checking bench for seque_gen: directed corner cases plus random transfers vs. a cycle list model.
module tb_seque_gen;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seque_gen_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

    seque_gen #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] observe();
        return {bus.busy, bus.done, bus.bit_valid, bus.sequence_out};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed {busy,done,valid,seq}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.pattern_in = 16'($urandom);
        bus.length_in  = 5'($urandom);
        bus.repeat_in  = 8'($urandom);
        bus.gap_in     = 4'($urandom);
    endtask

    // Expected per-cycle {busy,done,valid,seq} from T0+1 onward, ending with one idle cycle.
    task automatic run_txn(input logic [15:0] pat, input logic [4:0] len, input logic [7:0] rep,
                           input logic [3:0] gap, input bit poke, input string tag,
                           input int stop_after);
        logic [3:0] exp_q[$];
        int         el;
        int         er;
        el = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        er = (rep == 8'd0) ? 1 : int'(rep);
        if (el != 0) begin
            for (int r = 0; r < er; r++) begin
                for (int i = el - 1; i >= 0; i--) exp_q.push_back({3'b101, pat[i]});
                if (r != er - 1)
                    for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b1000);
            end
        end
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0000);

        @(negedge clock);
        bus.pattern_in = pat;
        bus.length_in  = len;
        bus.repeat_in  = rep;
        bus.gap_in     = gap;
        bus.start      = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clock);
            check($sformatf("%s[T0+%0d]", tag, k), observe(), exp_q[k-1]);
            bus.start = poke && (k == 1);
            scramble_inputs();
            if (stop_after != 0 && k == stop_after) break;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.pattern_in = '0;
        bus.length_in  = '0;
        bus.repeat_in  = '0;
        bus.gap_in     = '0;
        repeat (2) @(negedge clock);
        check("reset_state", observe(), 4'b0000);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", observe(), 4'b0000);

        run_txn(16'b111011011, 5'd9, 8'd1, 4'd0, 1'b0, "p9_r1", 0);
        run_txn(16'b1011, 5'd4, 8'd3, 4'd2, 1'b0, "p4_r3_g2", 0);
        run_txn(16'b1011, 5'd4, 8'd2, 4'd0, 1'b0, "p4_r2_g0", 0);
        run_txn(16'hbeef, 5'd0, 8'd3, 4'd5, 1'b0, "len0", 0);
        run_txn(16'b101, 5'd3, 8'd0, 4'd7, 1'b0, "rep0", 0);
        run_txn(16'hc3a5, 5'd31, 8'd1, 4'd3, 1'b1, "clamp31_poke", 0);
        run_txn(16'h5a0f, 5'd16, 8'd2, 4'd15, 1'b1, "gap15", 0);
        run_txn(16'h0002, 5'd2, 8'd255, 4'd0, 1'b0, "rep255", 0);

        // Abort a length-8 transfer mid-flight; outputs must clear without waiting for a clock.
        run_txn(16'($urandom), 5'd8, 8'd1, 4'd0, 1'b0, "abort", 3);
        #2 reset = 1'b0;
        #1 check("async_reset_clear", observe(), 4'b0000);
        repeat (2) begin
            @(negedge clock);
            check("held_in_reset", observe(), 4'b0000);
        end
        reset = 1'b1;
        @(negedge clock);
        check("no_done_after_abort", observe(), 4'b0000);
        run_txn(16'h00a7, 5'd8, 8'd2, 4'd1, 1'b0, "after_abort", 0);

        for (int n = 0; n < 25; n++) begin
            run_txn(16'($urandom), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 4)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", n), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seque_gen.md
# seque_gen

Serial pattern generator: the transmit-side counterpart of `seque_detect`. It latches a parallel bit pattern, a length, a repeat count and an inter-repeat gap, then shifts the pattern out MSB-first, one bit per clock, on `sequence_out`. Its output drives the `sequence_in` of `seque_detect` in loopback benches and board-level tests.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits (2..32).
- `LEN_W`, 5: width of `length_in`; must satisfy 2^LEN_W > MAX_LEN.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `pattern_in`  in  MAX_LEN  pattern; bit `length-1` is sent first.
- `length_in`  in  LEN_W  number of pattern bits to send.
- `repeat_in`  in  8  number of pattern repetitions; 0 is treated as 1.
- `gap_in`  in  4  idle cycles inserted between repetitions.
- `sequence_out`  out  1  serial data; 0 whenever `bit_valid`=0.
- `bit_valid`  out  1  high while `sequence_out` carries a pattern bit.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - When `start`=1, latch `pattern_in`, the effective length, the effective repeats and `gap_in`.
  - Effective length = min(`length_in`, MAX_LEN). Effective repeats = max(`repeat_in`, 1).
  - If effective length = 0, go to DONE. Otherwise go to SHIFT with bit index = length-1 and repeats remaining = effective repeats.
- SHIFT:
  - Drive `sequence_out` = pattern[bit index] and `bit_valid`=1.
  - Decrement the bit index each cycle.
  - At bit index 0, decrement repeats remaining.
    - If repeats remain and gap > 0, go to GAP.
    - If repeats remain and gap = 0, reload the index and stay in SHIFT. Consecutive repetitions are back-to-back with no bubble.
    - If no repeats remain, go to DONE.
- GAP: hold `sequence_out`=0 and `bit_valid`=0 for exactly gap cycles, then go to SHIFT with the index reloaded to length-1.
- DONE: `done`=1 for one cycle, `busy` still 1, then go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- Input changes after the start cycle have no effect on the transfer in progress.
- Reset asserted mid-transfer aborts immediately; no `done` is produced.

## Timing
- Reset values: `sequence_out`=0, `bit_valid`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- Outputs are registered.
- `start` is sampled at edge T0. The first bit appears after T0, in cycle T0+1, with `busy`=1 from that same cycle.
- A transfer with length L, repeats R and gap G occupies R·L + (R−1)·G cycles of SHIFT/GAP, followed by 1 DONE cycle.
- `done` is high in cycle T0 + R·L + (R−1)·G + 1. `busy` falls in the following cycle.
- The earliest next accepted `start` is sampled in the first IDLE cycle after DONE.
- Length 0: `done` in cycle T0+1; `bit_valid` is never asserted.
- Counter widths: bit index LEN_W, repeat counter 8, gap counter 4.
  - The repeat counter never wraps; 255 repeats is the maximum.
  - A gap of 15 is the maximum.

## Structure
- Package `seque_pkg` holds:
  - the state enum (IDLE, SHIFT, GAP, DONE),
  - `REPEAT_W` = 8 and `GAP_W` = 4,
  - a `MIN_REPEAT` = 1 constant.
- One sub-module, `seque_piso`: a loadable MSB-first parallel-in serial-out register with load/shift enables and a variable length. The FSM and counters stay in `seque_gen`.

## Test plan
- Pattern 9'b111011011, length 9, repeat 1, gap 0. Required: `sequence_out` = 1,1,1,0,1,1,0,1,1 in cycles T0+1..T0+9; `done` in T0+10. Loopback into `seque_detect` must assert `detector_out` as its spec requires.
- Pattern 4'b1011, length 4, repeat 3, gap 2. Required: bits 1011 / 00 / 1011 / 00 / 1011, with `bit_valid` low during the gaps; `done` in T0+17.
- Pattern 4'b1011, length 4, repeat 2, gap 0. Required: 8 back-to-back valid bits 10111011; `done` in T0+9.
- Length 0 and separately repeat 0. Length 0 requires `done` in T0+1 with no valid bits. Repeat 0 with length 3 and pattern 3'b101 requires 101 sent once.
- `start` pulsed during SHIFT, and `length_in`=31 with MAX_LEN=16. The mid-transfer `start` must be ignored. The oversized length must be clamped to 16 bits.
- `reset` driven low at the bit-3 cycle of a length-8 transfer. All outputs must go to 0 asynchronously, no `done` pulse, and a new `start` after release must transfer normally.
